paddle_ctrl: RTL and testbench

PADDLE_CTRL -- requirements
Module: paddle_ctrl

---
 rtl/pong_pkg.sv | 30 +++
 rtl/debounce.sv | 46 ++++
 rtl/paddle_ctrl.sv | 143 ++++++++++++++
 tb/tb_paddle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the pong paddle logic: field geometry, the paddle
// FSM state encoding, the signed step direction, and a decoder that turns
// the two debounced buttons into a direction.
package pong_pkg;

    localparam int FIELD_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        HOLD  = 2'd2
    } paddle_state_t;

    // -1 = up, 0 = still, +1 = down
    typedef logic signed [1:0] dir_t;

    // Up-only moves toward row 0, down-only toward the bottom, both or
    // neither cancel out.
    function automatic dir_t dir_from(input logic up, input logic down);
        dir_t d;
        d = 2'sd0;
        if (up && !down) begin
            d = -2'sd1;
        end else if (down && !up) begin
            d = 2'sd1;
        end
        return d;
    endfunction

endpackage

// File: rtl/debounce.sv
// Two-flop synchroniser followed by a debouncer for one raw button.
// The output only follows the synchronised level after that level has
// disagreed with the output for DEBOUNCE_CYCLES consecutive clocks; any
// return to agreement restarts the count.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 6000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments make sync[1] take the old sync[0], giving two real flop stages.
            sync <= {sync[0], raw};
        end
    end

    // Count consecutive cycles of disagreement and accept the new level at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync[1] != level) begin
            if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller. Two debounced buttons give a direction; the
// FSM steps the paddle once on the first tick of a press and, when
// PADDLE_AUTOREPEAT_EN is defined, again every REPEAT_TICKS ticks while the
// same direction is held. Without the macro a press steps exactly once and
// the FSM waits in PRESS for release. Releasing or reversing drops back to
// IDLE on the next clk without stepping. The paddle is clamped to
// 0..FIELD_SIZE-PADDLE_LEN, and a clamped step does not pulse moved.
module paddle_ctrl
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 6000,
    parameter int PADDLE_LEN      = 4,
    parameter int REPEAT_TICKS    = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] paddle_y,
    output logic       moved
);

    localparam logic [3:0] MAX_Y  = 4'(FIELD_SIZE - PADDLE_LEN);
    localparam logic [3:0] HOME_Y = 4'((FIELD_SIZE - PADDLE_LEN) / 2);

    logic up_level;
    logic down_level;
    dir_t dir;

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_up),
        .level   (up_level)
    );

    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (btn_down),
        .level   (down_level)
    );

    assign dir = dir_from(up_level, down_level);

    paddle_state_t state_q, state_d;
    dir_t          run_dir_q, run_dir_d;
    logic [3:0]    y_d;
    logic          moved_d;
    logic          step_req;

`ifdef PADDLE_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_TICKS + 1);
    logic [RPT_W-1:0] cnt_q, cnt_d;
`endif

    // Candidate position in 5-bit signed form so a step off either edge is
    // seen as out of range instead of wrapping.
    logic signed [4:0] next_pos;
    logic              in_range;

    assign next_pos = $signed({1'b0, paddle_y}) + $signed({{3{dir[1]}}, dir});
    assign in_range = !next_pos[4] && (next_pos[3:0] <= MAX_Y);

    // Next-state, repeat-counter and position decision.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch behind.
        state_d   = state_q;
        run_dir_d = run_dir_q;
        y_d       = paddle_y;
        moved_d   = 1'b0;
        step_req  = 1'b0;
`ifdef PADDLE_AUTOREPEAT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (tick && (dir != 2'sd0)) begin
                    step_req  = 1'b1;
                    run_dir_d = dir;
                    state_d   = PRESS;
`ifdef PADDLE_AUTOREPEAT_EN
                    cnt_d     = RPT_W'(REPEAT_TICKS);
`endif
                end
            end
            PRESS, HOLD: begin
                if (dir != run_dir_q) begin
                    // Release or reversal: leave immediately, no step.
                    state_d = IDLE;
                end
`ifdef PADDLE_AUTOREPEAT_EN
                else if (tick) begin
                    if (cnt_q == RPT_W'(1)) begin
                        step_req = 1'b1;
                        cnt_d    = RPT_W'(REPEAT_TICKS);
                        state_d  = HOLD;
                    end else begin
                        cnt_d = cnt_q - RPT_W'(1);
                    end
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (step_req && in_range) begin
            y_d     = next_pos[3:0];
            moved_d = 1'b1;
        end
    end

    // State, direction and position registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            run_dir_q <= 2'sd0;
            paddle_y  <= HOME_Y;
            moved     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_dir_q <= run_dir_d;
            paddle_y  <= y_d;
            moved     <= moved_d;
        end
    end

`ifdef PADDLE_AUTOREPEAT_EN
    // Repeat counter, only present when auto-repeat is built in.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_paddle_ctrl.sv
// Self-checking bench for paddle_ctrl with DEBOUNCE_CYCLES=4, REPEAT_TICKS=3,
// PADDLE_LEN=4 and a tick every 10 clk. A behavioural model follows the
// button rules cycle by cycle; directed scenarios pin it with literal values,
// then random button activity exercises it further.
module tb_paddle_ctrl;

    localparam int DB   = 4;
    localparam int RT   = 3;
    localparam int PL   = 4;
    localparam int MAXY = 16 - PL;
    localparam int HOME = (16 - PL) / 2;
`ifdef PADDLE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       tick     = 1'b0;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] paddle_y;
    logic       moved;

    int pass_cnt   = 0;
    int total_cnt  = 0;
    int moved_seen = 0;

    paddle_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .PADDLE_LEN      (PL),
        .REPEAT_TICKS    (RT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tick),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .paddle_y (paddle_y),
        .moved    (moved)
    );

    always #5 clk = ~clk;

    // One-clk tick every 10 clk, changed just after the rising edge.
    initial begin
        int n;
        n = 0;
        forever begin
            @(posedge clk);
            #1;
            tick = (n == 9);
            n = (n + 1) % 10;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        total_cnt++;
        if (actual == expected) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_y;
    bit m_moved;
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_db [2];
    int m_run[2];
    bit m_held;
    int m_hdir;
    int m_since;

    function automatic int dir_of(input bit up, input bit dn);
        return (dn ? 1 : 0) - (up ? 1 : 0);
    endfunction

    task automatic m_try(input int d);
        int np;
        np = m_y + d;
        if (np >= 0 && np <= MAXY) begin
            m_y     = np;
            m_moved = 1'b1;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        int d;
        bit raw [2];
        if (!reset_n) begin
            m_y     = HOME;
            m_moved = 1'b0;
            m_held  = 1'b0;
            m_hdir  = 0;
            m_since = 0;
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 1'b0; m_s2[b] = 1'b0; m_db[b] = 1'b0; m_run[b] = 0;
            end
        end else begin
            raw[0]  = btn_up;
            raw[1]  = btn_down;
            d       = dir_of(m_db[0], m_db[1]);
            m_moved = 1'b0;
            if (!m_held) begin
                if (tick && d != 0) begin
                    m_try(d);
                    m_held  = 1'b1;
                    m_hdir  = d;
                    m_since = 0;
                end
            end else if (d != m_hdir) begin
                m_held = 1'b0;
            end else if (tick && AR) begin
                m_since++;
                if (m_since == RT) begin
                    m_try(d);
                    m_since = 0;
                end
            end
            for (int b = 0; b < 2; b++) begin
                if (m_s2[b] != m_db[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DB) begin
                        m_db[b]  = m_s2[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
                m_s2[b] = m_s1[b];
                m_s1[b] = raw[b];
            end
        end
    end

    // Compare outputs to the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("paddle_y_vs_model", int'(paddle_y), m_y);
            check("moved_vs_model", int'(moved), int'(m_moved));
            if (moved) moved_seen++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            int guard;
            guard = 0;
            @(negedge clk);
            while (!tick && guard < 20) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 20) check("tick_timeout", 0, 1);
            @(negedge clk);
        end
    endtask

    task automatic set_reset(input logic v);
        @(posedge clk);
        #1;
        reset_n = v;
    endtask

    task automatic press_once(input bit up);
        if (up) btn_up = 1'b1; else btn_down = 1'b1;
        wait_clk(10);
        wait_ticks(1);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_clk(20);
    endtask

    initial begin
        int mv0;

        // Reset release
        wait_clk(3);
        set_reset(1'b1);
        wait_clk(2);
        check("reset_y", int'(paddle_y), 6);
        check("reset_moved", int'(moved), 0);

        // Bounce rejection: toggle every 2 clk for 40 clk
        mv0 = moved_seen;
        for (int i = 0; i < 20; i++) begin
            btn_up = ~btn_up;
            wait_clk(2);
        end
        btn_up = 1'b0;
        wait_clk(20);
        check("bounce_y", int'(paddle_y), 6);
        check("bounce_moves", moved_seen - mv0, 0);

        // Single press of btn_down
        mv0 = moved_seen;
        btn_down = 1'b1;
        wait_clk(10);
        wait_ticks(1);
        btn_down = 1'b0;
        wait_ticks(2);
        check("single_y", int'(paddle_y), 7);
        check("single_moves", moved_seen - mv0, 1);

        // Hold btn_down from home, then reset mid-hold
        set_reset(1'b0);
        wait_clk(3);
        set_reset(1'b1);
        wait_clk(2);
        check("rehome_y", int'(paddle_y), 6);
        btn_down = 1'b1;
        wait_clk(10);
        wait_ticks(1);
        check("hold_first", int'(paddle_y), 7);
        wait_ticks(3);
        check("hold_second", int'(paddle_y), AR ? 8 : 7);
        wait_ticks(3);
        check("hold_third", int'(paddle_y), AR ? 9 : 7);
        wait_clk(3);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("midhold_reset_y", int'(paddle_y), 6);
        check("midhold_reset_moved", int'(moved), 0);
        btn_down = 1'b0;
        wait_clk(3);
        set_reset(1'b1);
        wait_clk(20);
        check("resume_y", int'(paddle_y), 6);

        // Both buttons together: no movement
        mv0 = moved_seen;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        wait_clk(10);
        wait_ticks(4);
        check("both_y", int'(paddle_y), 6);
        check("both_moves", moved_seen - mv0, 0);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_clk(20);

        // Reversal: up held, down added, up released
        btn_up = 1'b1;
        wait_clk(10);
        wait_ticks(1);
        check("rev_up_y", int'(paddle_y), 5);
        btn_down = 1'b1;
        wait_clk(10);
        mv0 = moved_seen;
        wait_ticks(4);
        check("rev_both_y", int'(paddle_y), 5);
        check("rev_both_moves", moved_seen - mv0, 0);
        btn_up = 1'b0;
        wait_clk(10);
        wait_ticks(1);
        check("rev_down_y", int'(paddle_y), 6);
        btn_down = 1'b0;
        wait_clk(20);

        // Clamp at the top
        repeat (5) press_once(1'b1);
        check("up_to_1", int'(paddle_y), 1);
        mv0 = moved_seen;
        btn_up = 1'b1;
        wait_clk(10);
        wait_ticks(1);
        check("clamp_lo_reach", int'(paddle_y), 0);
        wait_ticks(7);
        check("clamp_lo_stay", int'(paddle_y), 0);
        check("clamp_lo_moves", moved_seen - mv0, 1);
        btn_up = 1'b0;
        wait_clk(20);

        // Clamp at the bottom
        repeat (11) press_once(1'b0);
        check("down_to_11", int'(paddle_y), 11);
        mv0 = moved_seen;
        btn_down = 1'b1;
        wait_clk(10);
        wait_ticks(1);
        check("clamp_hi_reach", int'(paddle_y), 12);
        wait_ticks(7);
        check("clamp_hi_stay", int'(paddle_y), 12);
        check("clamp_hi_moves", moved_seen - mv0, 1);
        btn_down = 1'b0;
        wait_clk(20);

        // Random button activity, occasional reset
        for (int i = 0; i < 150; i++) begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            wait_clk(int'($urandom_range(1, 40)));
            if ($urandom_range(0, 49) == 0) begin
                set_reset(1'b0);
                wait_clk(2);
                set_reset(1'b1);
            end
        end
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_clk(20);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
